// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready-handshaked ALU with carry/zero/overflow/negative
// flags and barrel shifts. Define ALU_MUL_EN to add the multi-cycle shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             neg
);

  localparam int K   = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_INC = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;

`ifdef ALU_MUL_EN
  localparam logic [3:0]   OP_MUL = 4'b1000;
  localparam logic [K-1:0] LAST   = K'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t state_q, state_d;
  logic   load_alu, load_mul, start_mul;

  logic [WIDTH-1:0] alu_y;
  logic             alu_cout, alu_ovf;
  logic [K-1:0]     amt;

  assign amt = b[K-1:0];

  // Single-cycle datapath for every opcode except multiply.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    alu_y    = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (s)
      OP_ADD: begin
        {alu_cout, alu_y} = {1'b0, a} + {1'b0, b};
        alu_ovf = (a[MSB] == b[MSB]) && (alu_y[MSB] != a[MSB]);
      end
      OP_SUB: begin
        {alu_cout, alu_y} = {1'b0, a} - {1'b0, b};
        alu_ovf = (a[MSB] != b[MSB]) && (alu_y[MSB] != a[MSB]);
      end
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_XOR: alu_y = a ^ b;
      OP_NOT: alu_y = ~a;
      OP_INC: begin
        {alu_cout, alu_y} = {1'b0, a} + (WIDTH+1)'(1);
        alu_ovf = (a == {1'b0, {(WIDTH-1){1'b1}}});
      end
      // The extra bit beside the operand catches the last bit shifted out (0 for amount 0).
      OP_SHL: {alu_cout, alu_y} = {1'b0, a} << amt;
      OP_SHR: {alu_y, alu_cout} = {a, 1'b0} >> amt;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [K-1:0]       cnt_q;

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    start_mul = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
`ifdef ALU_MUL_EN
      MUL: begin
        if (cnt_q == LAST) begin
          load_mul = 1'b1;
          state_d  = DONE;
        end
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Accepting in DONE overrides the return to IDLE: back-to-back with no bubble.
    if (in_valid && in_ready) begin
`ifdef ALU_MUL_EN
      if (s == OP_MUL) begin
        start_mul = 1'b1;
        state_d   = MUL;
      end else
`endif
      begin
        load_alu = 1'b1;
        state_d  = DONE;
      end
    end
  end

  // Result registers only move on the edge that loads a new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= '0;
      cout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
      neg  <= 1'b0;
`ifdef ALU_MUL_EN
      y_hi     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      if (load_alu) begin
        y    <= alu_y;
        cout <= alu_cout;
        zero <= (alu_y == '0);
        ovf  <= alu_ovf;
        neg  <= alu_y[MSB];
`ifdef ALU_MUL_EN
        y_hi <= '0;
`endif
      end
`ifdef ALU_MUL_EN
      if (start_mul) begin
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == MUL) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (load_mul) begin
        y    <= acc_d[WIDTH-1:0];
        y_hi <= acc_d[2*WIDTH-1:WIDTH];
        cout <= |acc_d[2*WIDTH-1:WIDTH];
        zero <= (acc_d == '0);
        ovf  <= 1'b0;
        neg  <= acc_d[2*WIDTH-1];
      end
`endif
    end
  end

`ifndef ALU_MUL_EN
  assign y_hi = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors, multi-cycle corner sequences and randomized
// handshake traffic for alu_seq (WIDTH=8), checked against an arithmetic model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y, y_hi;
  logic [3:0] s;
  logic       cout, zero, ovf, neg;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .cout(cout), .zero(zero), .ovf(ovf), .neg(neg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] y_hi;
    logic       cout;
    logic       zero;
    logic       ovf;
    logic       neg;
  } res_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       cout;
    logic       zero;
    logic       ovf;
    logic       neg;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_res(input string name, input res_t e);
    check({name, ".y"},    32'(y),    32'(e.y));
    check({name, ".y_hi"}, 32'(y_hi), 32'(e.y_hi));
    check({name, ".cout"}, 32'(cout), 32'(e.cout));
    check({name, ".zero"}, 32'(zero), 32'(e.zero));
    check({name, ".ovf"},  32'(ovf),  32'(e.ovf));
    check({name, ".neg"},  32'(neg),  32'(e.neg));
  endtask

  // Reference model: plain integer arithmetic over the opcode rules.
  function automatic res_t model(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib);
    res_t m = '0;
    int   ua = int'(ia);
    int   ub = int'(ib);
    int   sa = int'($signed(ia));
    int   sb = int'($signed(ib));
    int   n  = int'(ib[2:0]);
    int   r;
    int   sr;
    case (op)
      4'd0: begin r = ua + ub; m.y = r[7:0]; m.cout = (r > 255);
                  sr = sa + sb; m.ovf = (sr > 127) || (sr < -128); end
      4'd1: begin r = ua - ub; m.y = r[7:0]; m.cout = (ua < ub);
                  sr = sa - sb; m.ovf = (sr > 127) || (sr < -128); end
      4'd2: m.y = ia & ib;
      4'd3: m.y = ia | ib;
      4'd5: m.y = ia ^ ib;
      4'd6: m.y = ~ia;
      4'd7: begin r = ua + 1; m.y = r[7:0]; m.cout = (r > 255); m.ovf = (sa + 1 > 127); end
      4'd8: if (MUL_EN) begin r = ua * ub; m.y = r[7:0]; m.y_hi = r[15:8]; m.cout = (m.y_hi != 0); end
      4'd9: begin r = ua << n; m.y = r[7:0]; m.cout = (n == 0) ? 1'b0 : ua[8-n]; end
      4'd10: begin m.y = 8'(ua >> n); m.cout = (n == 0) ? 1'b0 : ua[n-1]; end
      default: ;
    endcase
    m.zero = (m.y == 0) && (m.y_hi == 0);
    m.neg  = (op == 4'd8 && MUL_EN) ? m.y_hi[7] : m.y[7];
    return m;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[18];
  res_t e;
  res_t q[$];
  bit   took;

  initial begin
    vecs[0]  = '{"add_wrap",   4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"add_ovf",    4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{"sub_borrow", 4'h1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{"sub_equal",  4'h1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"sub_ovf",    4'h1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"inc_ovf",    4'h7, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{"inc_wrap",   4'h7, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"xor_zero",   4'h5, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"and",        4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"or",         4'h3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{"not",        4'h6, 8'h55, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{"shl_1",      4'h9, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"shr_0",      4'hA, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{"shr_7",      4'hA, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{"shl_7",      4'h9, 8'h03, 8'h07, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{"shl_amt_lo", 4'h9, 8'h01, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{"op_4",       4'h4, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{"op_f",       4'hF, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; s = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_res("reset", '0);
    check("reset.out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset.in_ready", 32'(in_ready), 1);

    // Reset in the middle of a multiply (or, without it, over a held default result).
    @(negedge clk);
    in_valid = 1'b1; s = 4'h8; a = 8'd15; b = 8'd15;
    @(negedge clk);
    in_valid = 1'b0;
    if (MUL_EN) begin
      check("midmul.in_ready", 32'(in_ready), 0);
      check("midmul.out_valid", 32'(out_valid), 0);
    end else begin
      check("nomul.out_valid", 32'(out_valid), 1);
      check("nomul.zero", 32'(zero), 1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_res("midrst", '0);
    check("midrst.out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst.in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; s = 4'h0; a = 8'd1; b = 8'd1; out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_add.out_valid", 32'(out_valid), 1);
    check("post_rst_add.y", 32'(y), 2);
    in_valid = 1'b0;
    @(negedge clk);
    check("hold.out_valid", 32'(out_valid), 0);
    check("hold.y", 32'(y), 2);

    // Directed vectors streamed back-to-back, one result per cycle.
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; s = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      check({vecs[i].name, ".out_valid"}, 32'(out_valid), 1);
      check_res(vecs[i].name, '{vecs[i].y, 8'h00, vecs[i].cout, vecs[i].zero, vecs[i].ovf, vecs[i].neg});
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Multiply 0xFF * 0xFF.
    in_valid = 1'b1; s = 4'h8; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    if (MUL_EN) begin
      for (int i = 0; i < 8; i++) begin
        check("mul.busy_out_valid", 32'(out_valid), 0);
        check("mul.busy_in_ready", 32'(in_ready), 0);
        @(negedge clk);
      end
      check("mul.out_valid", 32'(out_valid), 1);
      check_res("mul", '{8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1});
    end else begin
      check("mul_off.out_valid", 32'(out_valid), 1);
      check_res("mul_off", '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);

    // Backpressure: result frozen for 5 cycles, then a stream of 4 adds.
    out_ready = 1'b0;
    in_valid = 1'b1; s = 4'h0; a = 8'h12; b = 8'h34;
    @(negedge clk);
    s = 4'h1; a = 8'h09; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall.out_valid", 32'(out_valid), 1);
      check("stall.y", 32'(y), 32'h46);
      check("stall.in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 4'h0; a = 8'(16 * i + 1); b = 8'd3;
      @(negedge clk);
      check("stream.out_valid", 32'(out_valid), 1);
      check("stream.y", 32'(y), 32'(16 * i + 4));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_end.out_valid", 32'(out_valid), 0);
    check("stream_end.y", 32'(y), 32'h34);

    // Randomized traffic with random stalls against the model.
    took = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        s = 4'($urandom_range(0, 15));
        a = 8'($urandom);
        b = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rand.unexpected_result", 32'(out_valid), 0);
        else begin
          e = q.pop_front();
          check_res("rand", e);
        end
      end
      took = in_valid && in_ready;
      if (took) q.push_back(model(s, a, b));
    end

    // Drain outstanding results within a bounded number of cycles.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) check("drain.unexpected_result", 32'(out_valid), 0);
        else begin
          e = q.pop_front();
          check_res("drain", e);
        end
      end
      @(negedge clk);
    end
    check("drain.pending", 32'(q.size()), 0);
    check("drain.out_valid", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the same opcode map for add, sub, and, or, xor, not and inc, and adds registered results, a valid/ready interface on both sides, signed-overflow and negative flags, barrel shifts, and an optional multi-cycle shift-add multiplier. It sits between an operand-issuing controller and a result consumer that may stall.

## Interface
- WIDTH, 8, operand/result width (≥4, power of 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (low log2(WIDTH) bits = shift amount for shifts)
- s  in  4  opcode
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result (low half for multiply)
- y_hi  out  WIDTH  upper product half; 0 for all other ops
- cout  out  1  carry/borrow/shift-out/high-nonzero
- zero  out  1  full result ({y_hi,y}) == 0
- ovf  out  1  signed overflow
- neg  out  1  y[WIDTH-1] (y_hi MSB for multiply)

## Operation
- Opcodes: 0000 add {cout,y}=a+b; 0001 sub {cout,y}=a−b (cout=1 iff a<b unsigned); 0010 and; 0011 or; 0101 xor; 0110 y=~a; 0111 inc {cout,y}=a+1; 1000 unsigned multiply {y_hi,y}=a*b; 1001 shl y=a<<b[k−1:0]; 1010 shr (logical) y=a>>b[k−1:0]; all others y=0.
- cout: logic ops/default = 0; shifts = last bit shifted out, 0 for amount 0; multiply = |y_hi.
- ovf: add = a,b same sign and y sign differs; sub = a,b signs differ and y sign ≠ a sign; inc = (a == 0111…1); all others 0.
- FSM states IDLE, MUL, DONE.
  - IDLE: in_ready=1. On accept of non-multiply → compute, register results → DONE. On accept of 1000 → latch a,b, clear accumulator → MUL.
  - MUL: in_ready=0; one shift-add iteration per cycle, WIDTH iterations, then register product and flags → DONE.
  - DONE: out_valid=1; outputs stable. in_ready = out_ready. If out_ready && in_valid → new op accepted same edge (back-to-back); else if out_ready → IDLE.
- Outputs change only on the edge that loads a new result; they hold after out_valid drops.

## Timing
- Reset (rst_n low, any state, including mid-multiply): state IDLE, y=0, y_hi=0, cout=0, zero=0, ovf=0, neg=0, out_valid=0, accumulator cleared; partial product discarded. in_ready reads 1 once rst_n rises; in_valid ignored while rst_n low.
- Non-multiply latency: accept at edge k → out_valid high after edge k; one result per cycle with out_ready held high.
- Multiply latency: accept at edge k → out_valid after edge k+WIDTH.
- Stall: out_ready low keeps out_valid and all result outputs frozen indefinitely; in_ready stays 0.
- Simultaneous out_ready and in_valid in DONE: old result consumed and new op accepted on the same edge, with no bubble.

## Configuration
- ALU_MUL_EN defined: opcode 1000 runs the multiplier and MUL state as above.
- ALU_MUL_EN undefined: no multiplier or MUL state is synthesised. 1000 falls to the default path (single-cycle, y=0, y_hi=0, zero=1, other flags 0). y_hi is tied to 0.

## Test plan
- Reset mid-multiply (WIDTH=8, a=15, b=15, rst_n low at cycle 3) → all outputs 0, out_valid 0, in_ready 1 after release; a subsequent add 1+1 gives y=2.
- Add 0xFF+0x01 → y=0x00, cout=1, zero=1, ovf=0. Add 0x7F+0x01 → y=0x80, ovf=1, neg=1. Both results appear one cycle after accept.
- Sub 0x03−0x05 → y=0xFE, cout=1, neg=1. Inc 0x7F → y=0x80, ovf=1. xor 0xAA^0xAA → y=0, zero=1.
- Multiply 0xFF*0xFF (ALU_MUL_EN) → y=0x01, y_hi=0xFE, cout=1, out_valid exactly 8 cycles after accept, in_ready 0 throughout. Without the macro → y=0, zero=1 after 1 cycle.
- Shifts: shl 0x81 by 1 → y=0x02, cout=1. shr 0x81 by 0 → y=0x81, cout=0. shr 0x80 by 7 → y=0x01.
- Backpressure: hold out_ready=0 for 5 cycles → outputs frozen, in_ready=0. Then stream 4 adds with out_ready=1 → one result per cycle, none lost or duplicated.
